// File: rtl/tagged_array_reader_if.sv
// tagged_array_reader_if: write, request and response channels of the tagged array read port
interface tagged_array_reader_if;
    logic       wr_en;
    logic [3:0] wr_idx;
    logic [2:0] wr_data;
    logic       wr_tag;
    logic       req_valid;
    logic       req_ready;
    logic [3:0] req_idx;
    logic       req_sweep;
    logic       req_level;
    logic       resp_valid;
    logic       resp_ready;
    logic [3:0] resp_idx;
    logic [2:0] resp_data;
    logic       resp_tag;
    logic       resp_denied;
    logic       resp_last;
    modport master (
        output wr_en, wr_idx, wr_data, wr_tag,
        output req_valid, req_idx, req_sweep, req_level, resp_ready,
        input  req_ready, resp_valid, resp_idx, resp_data, resp_tag, resp_denied, resp_last
    );
    modport slave (
        input  wr_en, wr_idx, wr_data, wr_tag,
        input  req_valid, req_idx, req_sweep, req_level, resp_ready,
        output req_ready, resp_valid, resp_idx, resp_data, resp_tag, resp_denied, resp_last
    );
endinterface

// File: rtl/tagged_array_reader.sv
// tagged_array_reader: 16x3 tagged array with clearance-masked single and sweep reads
module tagged_array_reader (
    input logic                  clk,
    input logic                  reset,
    tagged_array_reader_if.slave bus
);
    typedef enum logic [1:0] {IDLE, SINGLE, SWEEP} state_t;
    state_t            r_state, w_next;
    logic [15:0][2:0]  r_data;
    logic [15:0]       r_tags;
    logic              r_level, r_stag, r_last;
    logic [2:0]        r_sdata;
    logic [3:0]        r_idx;
    logic              w_valid, w_accept, w_hs, w_adv, w_load, w_denied;
    logic [3:0]        w_sidx;
    always_comb begin
        w_valid  = r_state != IDLE;
        w_accept = r_state == IDLE && bus.req_valid;
        w_hs     = w_valid && bus.resp_ready;
        w_adv    = w_hs && r_state == SWEEP && r_idx != 4'd15;
        w_load   = w_accept || w_adv;
        w_sidx   = w_adv ? r_idx + 4'd1 : (bus.req_sweep ? 4'd0 : bus.req_idx);
        w_next   = w_accept ? (bus.req_sweep ? SWEEP : SINGLE) :
                   (w_hs && !w_adv) ? IDLE : r_state;
        w_denied = r_stag & ~r_level;
    end
    // Sampling uses pre-edge array contents, so a same-edge write never leaks into the beat
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_tags  <= '1;
            r_data  <= '0;
            r_level <= 1'b0;
            r_stag  <= 1'b0;
            r_last  <= 1'b0;
            r_sdata <= '0;
            r_idx   <= '0;
        end else begin
            r_state <= w_next;
            if (bus.wr_en) begin
                r_data[bus.wr_idx] <= bus.wr_data;
                r_tags[bus.wr_idx] <= bus.wr_tag;
            end
            if (w_accept)
                r_level <= bus.req_level;
            if (w_load) begin
                r_idx   <= w_sidx;
                r_sdata <= r_data[w_sidx];
                r_stag  <= r_tags[w_sidx];
                r_last  <= w_accept ? !bus.req_sweep : w_sidx == 4'd15;
            end
        end
    end
    assign bus.req_ready   = r_state == IDLE && !reset;
    assign bus.resp_valid  = w_valid;
    assign bus.resp_idx    = r_idx;
    assign bus.resp_tag    = r_stag;
    assign bus.resp_denied = w_denied;
    assign bus.resp_data   = w_denied ? 3'd0 : r_sdata;
    assign bus.resp_last   = r_last;
endmodule

// File: tb/tb_tagged_array_reader.sv
// tb_tagged_array_reader: directed checks of masking, sampling order, sweeps, stalls and reset
module tb_tagged_array_reader;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   tests = 0;
    int   fails = 0;
    tagged_array_reader_if bus();
    tagged_array_reader dut (.clk(clk), .reset(reset), .bus(bus));
    always #5 clk = ~clk;
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask
    task automatic chk_resp(input string tag, input logic v, input logic [3:0] idx,
                            input logic [2:0] d, input logic t, input logic den, input logic l);
        chk(tag, {5'd0, bus.resp_valid, bus.resp_idx, bus.resp_data, bus.resp_tag, bus.resp_denied, bus.resp_last},
                 {5'd0, v, idx, d, t, den, l});
    endtask
    task automatic write(input logic [3:0] idx, input logic [2:0] d, input logic t);
        bus.wr_en = 1'b1; bus.wr_idx = idx; bus.wr_data = d; bus.wr_tag = t;
        tick();
        bus.wr_en = 1'b0;
    endtask
    task automatic request(input logic [3:0] idx, input logic sweep, input logic level);
        bus.req_valid = 1'b1; bus.req_idx = idx; bus.req_sweep = sweep; bus.req_level = level;
        tick();
        bus.req_valid = 1'b0;
    endtask
    task automatic complete();
        bus.resp_ready = 1'b1;
        tick();
        bus.resp_ready = 1'b0;
    endtask
    initial begin
        logic [3:0] pat;
        int k;
        int cyc;
        bus.wr_en = 1'b0; bus.wr_idx = '0; bus.wr_data = '0; bus.wr_tag = 1'b0;
        bus.req_valid = 1'b0; bus.req_idx = '0; bus.req_sweep = 1'b0; bus.req_level = 1'b0;
        bus.resp_ready = 1'b0;
        tick();
        tick();
        chk_resp("reset_resp", 1'b0, 4'd0, 3'd0, 1'b0, 1'b0, 1'b0);
        chk("reset_ready", {15'd0, bus.req_ready}, 16'd0);
        reset = 1'b0;
        tick();
        chk("ready_after_reset", {15'd0, bus.req_ready}, 16'd1);
        request(4'd5, 1'b0, 1'b1);
        chk_resp("h_read_reset_tag", 1'b1, 4'd5, 3'd0, 1'b1, 1'b0, 1'b1);
        chk("ready_busy", {15'd0, bus.req_ready}, 16'd0);
        complete();
        write(4'd3, 3'd5, 1'b1);
        request(4'd3, 1'b0, 1'b0);
        chk_resp("l_read_masked", 1'b1, 4'd3, 3'd0, 1'b1, 1'b1, 1'b1);
        complete();
        request(4'd3, 1'b0, 1'b1);
        chk_resp("h_read_clear", 1'b1, 4'd3, 3'd5, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_resp("stall_hold", 1'b1, 4'd3, 3'd5, 1'b1, 1'b0, 1'b1);
        end
        complete();
        chk_resp("idle_after_single", 1'b0, 4'd3, 3'd5, 1'b1, 1'b0, 1'b1);
        chk("ready_after_single", {15'd0, bus.req_ready}, 16'd1);
        write(4'd7, 3'd2, 1'b0);
        bus.wr_en = 1'b1; bus.wr_idx = 4'd7; bus.wr_data = 3'd6; bus.wr_tag = 1'b1;
        request(4'd7, 1'b0, 1'b0);
        bus.wr_en = 1'b0;
        chk_resp("same_edge_old", 1'b1, 4'd7, 3'd2, 1'b0, 1'b0, 1'b1);
        complete();
        request(4'd7, 1'b0, 1'b0);
        chk_resp("same_edge_new", 1'b1, 4'd7, 3'd0, 1'b1, 1'b1, 1'b1);
        complete();
        for (int i = 0; i < 16; i++)
            write(4'(i), 3'(i % 8), 1'(i % 2));
        bus.resp_ready = 1'b1;
        request(4'd9, 1'b1, 1'b0);
        for (int i = 0; i < 16; i++) begin
            chk_resp("l_sweep_beat", 1'b1, 4'(i), (i % 2 == 1) ? 3'd0 : 3'(i % 8), 1'(i % 2), 1'(i % 2), 1'(i == 15));
            chk("sweep_ready", {15'd0, bus.req_ready}, 16'd0);
            tick();
        end
        bus.resp_ready = 1'b0;
        chk("ready_after_sweep", {15'd0, bus.req_ready, bus.resp_valid}, 16'd2);
        pat = 4'b1001;
        request(4'd0, 1'b1, 1'b1);
        bus.req_level = 1'b0;
        k = 0;
        cyc = 0;
        while (k < 16 && cyc < 100) begin
            bus.resp_ready = pat[cyc % 4];
            chk_resp("h_sweep_stall", 1'b1, 4'(k), 3'(k % 8), 1'(k % 2), 1'b0, 1'(k == 15));
            if (bus.resp_ready) k++;
            cyc++;
            tick();
        end
        bus.resp_ready = 1'b0;
        chk("h_sweep_beats", 16'(k), 16'd16);
        chk("ready_after_h_sweep", {15'd0, bus.req_ready, bus.resp_valid}, 16'd2);
        bus.resp_ready = 1'b1;
        request(4'd0, 1'b1, 1'b1);
        for (int i = 0; i < 6; i++) tick();
        chk_resp("beat6", 1'b1, 4'd6, 3'd6, 1'b0, 1'b0, 1'b0);
        reset = 1'b1;
        tick();
        bus.resp_ready = 1'b0;
        chk_resp("mid_sweep_reset", 1'b0, 4'd0, 3'd0, 1'b0, 1'b0, 1'b0);
        chk("ready_in_reset", {15'd0, bus.req_ready}, 16'd0);
        reset = 1'b0;
        tick();
        chk("ready_after_release", {15'd0, bus.req_ready, bus.resp_valid}, 16'd2);
        request(4'd2, 1'b0, 1'b1);
        chk_resp("tag_reset_h", 1'b1, 4'd2, 3'd0, 1'b1, 1'b0, 1'b1);
        complete();
        request(4'd4, 1'b0, 1'b0);
        chk_resp("tag_reset_l", 1'b1, 4'd4, 3'd0, 1'b1, 1'b1, 1'b1);
        complete();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
